// File: rtl/vga_plot_queue.sv
// Pixel-plot request FIFO between the CPU's VGA outputs and the framebuffer writer,
// with a hardware clear-screen sequencer that fills the visible area with CLEAR_COLOR.
module vga_plot_queue #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned X_MAX       = 159,
   parameter int unsigned Y_MAX       = 119,
   parameter logic [14:0] CLEAR_COLOR = 15'h0000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       vga_plot,
   input  logic [7:0]                 vga_x,
   input  logic [6:0]                 vga_y,
   input  logic [14:0]                vga_color,
   input  logic                       clear_req,
   input  logic                       fb_ready,
   output logic                       fb_plot,
   output logic [7:0]                 fb_x,
   output logic [6:0]                 fb_y,
   output logic [14:0]                fb_color,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       busy,
   output logic                       overflow,
   output logic                       range_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 30;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]    cx_q, cx_d;
   logic [6:0]    cy_q, cy_d;
   logic          overflow_q, overflow_d;
   logic          range_err_q, range_err_d;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] head;
   logic          in_range;
   logic          req_valid;
   logic          push;
   logic          pop;
   logic          in_clear;

   assign head     = mem_q[rd_ptr_q];
   assign in_clear = (state_q == ST_CLEAR);

   // Next-state: request qualification, FIFO bookkeeping and clear stepping
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      overflow_d  = overflow_q;
      range_err_d = range_err_q;
      push        = 1'b0;
      pop         = 1'b0;

      in_range  = (vga_x <= 8'(X_MAX)) && (vga_y <= 7'(Y_MAX));
      req_valid = vga_plot && in_range;
      if (vga_plot && !in_range) range_err_d = 1'b1;

      if (state_q == ST_RUN && clear_req) begin
         // Flush: a request arriving this cycle survives as the sole entry
         push     = req_valid;
         state_d  = ST_CLEAR;
         cx_d     = '0;
         cy_d     = '0;
         rd_ptr_d = wr_ptr_q;
         count_d  = push ? CW'(1) : '0;
      end else begin
         pop  = (state_q == ST_RUN) && (count_q != '0) && fb_ready;
         push = req_valid && ((count_q != CW'(DEPTH)) || pop);
         if (push && !pop) count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

         if (state_q == ST_CLEAR && fb_ready) begin
            if (cx_q == 8'(X_MAX)) begin
               cx_d = '0;
               if (cy_q == 7'(Y_MAX)) begin
                  cy_d    = '0;
                  state_d = ST_RUN;
               end else begin
                  cy_d = cy_q + 7'(1);
               end
            end else begin
               cx_d = cx_q + 8'(1);
            end
         end
      end

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (req_valid && !push) overflow_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         overflow_q  <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         overflow_q  <= overflow_d;
         range_err_q <= range_err_d;
      end
   end

   // Storage has no reset; only entries between the pointers are ever observed
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {vga_color, vga_x, vga_y};
   end

   assign fb_plot   = in_clear || (count_q != '0);
   assign fb_x      = in_clear ? cx_q : head[14:7];
   assign fb_y      = in_clear ? cy_q : head[6:0];
   assign fb_color  = in_clear ? CLEAR_COLOR : head[29:15];
   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));
   assign busy      = in_clear || (count_q != '0);
   assign overflow  = overflow_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_vga_plot_queue.sv
// Randomized bench for vga_plot_queue; a queue-based reference model predicts every output each cycle.
module tb_vga_plot_queue;

   localparam int DEPTH = 16;
   localparam int XM    = 159;
   localparam int YM    = 119;
   localparam int NCLR  = (XM + 1) * (YM + 1);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        vga_plot = 1'b0;
   logic [7:0]  vga_x = '0;
   logic [6:0]  vga_y = '0;
   logic [14:0] vga_color = '0;
   logic        clear_req = 1'b0;
   logic        fb_ready = 1'b0;
   logic        fb_plot;
   logic [7:0]  fb_x;
   logic [6:0]  fb_y;
   logic [14:0] fb_color;
   logic [4:0]  count;
   logic        full;
   logic        busy;
   logic        overflow;
   logic        range_err;

   vga_plot_queue dut (
      .clock(clock), .reset(reset), .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y),
      .vga_color(vga_color), .clear_req(clear_req), .fb_ready(fb_ready), .fb_plot(fb_plot),
      .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .count(count), .full(full),
      .busy(busy), .overflow(overflow), .range_err(range_err)
   );

   always #10 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: plain queue of {color,x,y}, clear progress as a linear beat index
   logic [29:0] mq[$];
   bit          m_clr;
   int          m_k;
   bit          m_ovf;
   bit          m_rerr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_clr  = 0;
      m_k    = 0;
      m_ovf  = 0;
      m_rerr = 0;
   endtask

   task automatic compare_outputs();
      bit   exp_plot;
      int   ex, ey, ec;
      exp_plot = m_clr || (mq.size() != 0);
      check_eq("fb_plot", 32'(fb_plot), 32'(exp_plot));
      if (exp_plot) begin
         if (m_clr) begin
            ex = m_k % (XM + 1);
            ey = m_k / (XM + 1);
            ec = 0;
         end else begin
            ec = int'(mq[0][29:15]);
            ex = int'(mq[0][14:7]);
            ey = int'(mq[0][6:0]);
         end
         check_eq("fb_x", 32'(fb_x), 32'(ex));
         check_eq("fb_y", 32'(fb_y), 32'(ey));
         check_eq("fb_color", 32'(fb_color), 32'(ec));
      end
      check_eq("count", 32'(count), 32'(mq.size()));
      check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
      check_eq("busy", 32'(busy), 32'(m_clr || mq.size() != 0));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("range_err", 32'(range_err), 32'(m_rerr));
   endtask

   task automatic model_update();
      bit valid, popped, room;
      if (reset) begin
         model_reset();
         return;
      end
      valid = vga_plot && (int'(vga_x) <= XM) && (int'(vga_y) <= YM);
      if (vga_plot && !valid) m_rerr = 1;
      if (!m_clr && clear_req) begin
         mq.delete();
         if (valid) mq.push_back({vga_color, vga_x, vga_y});
         m_clr = 1;
         m_k   = 0;
      end else begin
         popped = !m_clr && (mq.size() != 0) && fb_ready;
         room   = (mq.size() < DEPTH) || popped;
         if (m_clr && fb_ready) begin
            m_k++;
            if (m_k == NCLR) begin
               m_clr = 0;
               m_k   = 0;
            end
         end
         if (popped) void'(mq.pop_front());
         if (valid) begin
            if (room) mq.push_back({vga_color, vga_x, vga_y});
            else m_ovf = 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clock);
      compare_outputs();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      vga_plot  = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic drive(input int x, input int y, input int c);
      vga_plot  = 1'b1;
      vga_x     = 8'(x);
      vga_y     = 7'(y);
      vga_color = 15'(c);
   endtask

   initial begin
      int cyc;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      step();
      reset = 1'b0;

      // Single push with ready: one-cycle latency, then drains
      fb_ready = 1'b1;
      drive(5, 7, 'h7C00);
      step();
      idle();
      repeat (3) step();

      // Fill past full while stalled, then drain in order
      fb_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(i * 9, i * 7, $urandom);
         step();
      end
      idle();
      step();
      fb_ready = 1'b1;
      repeat (20) step();

      // Out-of-range coordinates at each boundary
      drive(160, 0, 'h1234);
      step();
      drive(0, 120, 'h1234);
      step();
      drive(XM, YM, 'h4321);
      step();
      idle();
      repeat (3) step();

      // Reset clears sticky flags
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Random plot traffic with random stalls
      for (int i = 0; i < 3000; i++) begin
         vga_plot  = ($urandom % 3) != 0;
         vga_x     = 8'($urandom_range(0, 165));
         vga_y     = 7'($urandom_range(0, 122));
         vga_color = 15'($urandom);
         fb_ready  = (i % 600 < 300) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         step();
      end
      idle();
      fb_ready = 1'b1;
      repeat (20) step();

      // Clear with 3 queued entries and a same-cycle push
      fb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(10 + i, 20 + i, 'h0100 + i);
         step();
      end
      drive(1, 1, 'h001F);
      clear_req = 1'b1;
      fb_ready  = 1'b1;
      step();
      idle();
      cyc = 0;
      while (busy === 1'b1 && cyc < NCLR + 100) begin
         step();
         cyc++;
      end
      check_eq("clear_len", 32'(cyc), 32'(NCLR + 1));

      // Clear under 50% backpressure, re-requests ignored, pushes queued meanwhile
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 3 * NCLR) begin
         fb_ready  = $urandom % 2;
         clear_req = (cyc % 5000) == 2500;
         vga_plot  = ($urandom % 40) == 0;
         vga_x     = 8'($urandom_range(0, XM));
         vga_y     = 7'($urandom_range(0, YM));
         vga_color = 15'($urandom);
         step();
         cyc++;
      end
      idle();
      check_eq("clear_bp_done", 32'(busy), 32'(0));

      // Reset mid-clear with two entries queued
      fb_ready  = 1'b0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      drive(3, 4, 'h0AAA);
      step();
      drive(5, 6, 'h0BBB);
      step();
      idle();
      fb_ready = 1'b1;
      repeat (100) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_plot", 32'(fb_plot), 32'(0));
      check_eq("rst_count", 32'(count), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_flags", 32'({overflow, range_err}), 32'(0));
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_plot_queue.md
Name: vga_plot_queue

Overview:
- Buffers pixel-plot requests from the flow CPU core (vga_x, vga_y, vga_color, vga_plot) and delivers them one per accepted beat to the VGA framebuffer writer over a ready/valid handshake.
- Decouples CPU plot bursts from framebuffer write stalls.
- Contains a hardware clear-screen sequencer that fills the whole visible area with a fixed colour.
- Sits directly downstream of the core's VGA outputs and upstream of the framebuffer adapter.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- X_MAX, 159, largest valid x coordinate.
- Y_MAX, 119, largest valid y coordinate.
- CLEAR_COLOR, 15'h0000, colour written by the clear sequencer.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- vga_plot  in  1  plot request strobe; one request per high cycle.
- vga_x  in  8  request x coordinate.
- vga_y  in  7  request y coordinate.
- vga_color  in  15  request colour.
- clear_req  in  1  starts a clear-screen sequence.
- fb_ready  in  1  framebuffer accepts the current beat.
- fb_plot  out  1  beat valid.
- fb_x  out  8  beat x coordinate.
- fb_y  out  7  beat y coordinate.
- fb_color  out  15  beat colour.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- full  out  1  count == DEPTH.
- busy  out  1  high in CLEAR, or whenever count != 0.
- overflow  out  1  sticky; a request was dropped because the FIFO was full.
- range_err  out  1  sticky; a request was out of range and discarded.

Behaviour:
- Clocking: single clock; reset is synchronous and active-high. All state updates on the posedge of clock.
- Reset values: state=RUN, count=0, rd/wr pointers=0, clear x/y counters=0, overflow=0, range_err=0. Outputs: fb_plot=0, busy=0, full=0. FIFO memory contents are don't-care.
- Reset mid-clear: abandons the sequence immediately; the next cycle is RUN with an empty FIFO.
- Entry format: {color, x, y}, 30 bits.
- Valid request: vga_plot=1, vga_x<=X_MAX and vga_y<=Y_MAX.
- Out-of-range request (vga_plot=1 with either coordinate out of range): not stored; range_err set.
- Push rule: a valid request is written when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Full with no pop: the request is dropped, count is unchanged, overflow is set.
- Pop: occurs when fb_plot && fb_ready.
- Simultaneous push and pop: count is unchanged.
- Pointers: wrap modulo DEPTH.
- Occupancy: count goes to 0..DEPTH inclusive; full = (count==DEPTH).
- RUN state outputs: fb_plot = (count!=0). fb_x/fb_y/fb_color show the head entry (show-ahead FIFO).
- Latency: a push in cycle N into an empty FIFO gives fb_plot=1 in cycle N+1.
- Beat hold: while fb_plot=1 and fb_ready=0, fb_* must hold stable.
- Entering CLEAR: clear_req=1 in RUN discards all FIFO contents (count <- 0, rd_ptr <- wr_ptr), loads cx=0, cy=0, and moves to CLEAR.
- Push in the clear_req cycle: a valid push in that same cycle is retained, becoming the only entry after the flush.
- CLEAR state outputs: fb_plot=1, fb_x=cx, fb_y=cy, fb_color=CLEAR_COLOR. The FIFO is not popped.
- CLEAR stepping: on fb_ready, cx increments. When cx==X_MAX, cx wraps to 0 and cy increments.
- CLEAR exit: an accepted beat at (X_MAX, Y_MAX) returns to RUN.
- CLEAR length: exactly (X_MAX+1)*(Y_MAX+1) accepted beats (19200 with defaults).
- clear_req while in CLEAR: ignored; no restart.
- Pushes during CLEAR: accepted normally (overflow rules apply) and drained after CLEAR ends.
- Sticky flags: overflow and range_err clear only on reset.

Test Plan:
1. Push (x=5, y=7, color=15'h7C00) with fb_ready=1 → fb_plot=1 one cycle later carrying exactly those values; count returns to 0.
2. fb_ready=0, push 17 valid requests → count=16, full=1, overflow=1. Then raise fb_ready → 16 beats emerge in push order and the 17th never appears.
3. Push x=160, y=0 → nothing stored, range_err=1, count=0. Then push y=120 → same result.
4. With 3 entries queued, assert clear_req together with a push of (1,1,15'h001F) → CLEAR emits 19200 beats, (0,0) through (159,119), all colour 0. Then a single beat (1,1,15'h001F) follows.
5. During CLEAR, toggle fb_ready at 50% → cx/cy advance only on accepted beats. clear_req re-asserted mid-sequence → no restart; total beat count still 19200.
6. Assert reset at beat 100 of CLEAR with 2 entries queued → next cycle fb_plot=0, count=0, busy=0, flags=0.
